// File: rtl/adder_cla_pipe_if.sv
// ---------------------------------------------------------------------------
// adder_cla_pipe_if
// Operand/result bundle for adder_cla_pipe.
//   master modport : operand producer and result consumer (drives inValid,
//                    a, b, inC, sub, outReady; observes inReady and results)
//   slave modport  : the adder itself
// Signals:
//   inValid/inReady   input-side handshake
//   a, b              operands, bit 0 = MSB ([0:WIDTH-1])
//   inC               carry in (add mode only)
//   sub               0: a + b + inC, 1: a - b
//   outValid/outReady output-side handshake
//   s                 result, bit 0 = MSB
//   outC, outV, outZ, outN  carry out, overflow, zero, negative
// ---------------------------------------------------------------------------
interface adder_cla_pipe_if #(
    parameter int WIDTH = 32
);
    logic             inValid;
    logic             inReady;
    logic [0:WIDTH-1] a;
    logic [0:WIDTH-1] b;
    logic             inC;
    logic             sub;
    logic             outValid;
    logic             outReady;
    logic [0:WIDTH-1] s;
    logic             outC;
    logic             outV;
    logic             outZ;
    logic             outN;

    modport master (
        output inValid, a, b, inC, sub, outReady,
        input  inReady, outValid, s, outC, outV, outZ, outN
    );

    modport slave (
        input  inValid, a, b, inC, sub, outReady,
        output inReady, outValid, s, outC, outV, outZ, outN
    );
endinterface

// File: rtl/adder_cla_pipe.sv
// ---------------------------------------------------------------------------
// adder_cla_pipe
// Pipelined carry-lookahead adder/subtractor. The operand is cut into
// WIDTH/4 4-bit lookahead groups; the groups are distributed LSB-first over
// STAGES register stages (earlier stages take the extra group when the
// split is uneven). Each stage resolves its groups, registers the partial
// sum, the carry into the next unresolved group and the still-unused
// operand bits. One operation per cycle, results in issue order, latency
// STAGES cycles.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active low
//   bus   adder_cla_pipe_if.slave (operands, results, handshakes)
//
// Build option:
//   ADDER_CLA_FLAGS_EN  when defined, outV/outZ/outN are computed in the
//                       last stage and registered with s; otherwise the
//                       flag outputs are tied to 0 and no flag logic exists.
// ---------------------------------------------------------------------------
module adder_cla_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    adder_cla_pipe_if.slave    bus
);
    localparam int GROUPS = WIDTH / 4;
    localparam int BASE   = GROUPS / STAGES;
    localparam int EXTRA  = GROUPS % STAGES;

    // First group handled by stage k; stages below EXTRA own one more group.
    function automatic int grp_start(input int k);
        return k * BASE + ((k < EXTRA) ? k : EXTRA);
    endfunction

    // Mask keeping only operand bits at or above group index hi.
    function automatic logic [WIDTH-1:0] upper_mask(input int hi);
        logic [WIDTH-1:0] m;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = (i >= hi * 4);
        end
        return m;
    endfunction

    // 4-bit lookahead group: returns {carry_out, sum[3:0]}.
    // g/p are formed per bit and every internal carry is a flat sum of
    // products, so there is no ripple inside the group.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g = x & y;
        p = x | y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], x ^ y ^ c[3:0]};
    endfunction

    // Operands re-expressed LSB-indexed; vector assignment keeps the
    // numeric value (bus bit 0 = MSB lands in bit WIDTH-1 here).
    // Subtraction is a + ~b + 1, so inC is ignored in that mode.
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_c;

    assign in_a = bus.a;
    assign in_b = bus.sub ? ~bus.b : bus.b;
    assign in_c = bus.sub | bus.inC;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int LO = grp_start(gi);
        localparam int HI = grp_start(gi + 1);

        logic             valid_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] sum_in;
        logic             c_in;

        logic             ready;
        logic             load;
        logic [WIDTH-1:0] sum_next;
        logic             c_next;

        logic             valid_reg;
        logic [WIDTH-1:0] sum_reg;
        logic             c_reg;

        if (gi == 0) begin : g_src
            assign valid_in = bus.inValid;
            assign a_in     = in_a;
            assign b_in     = in_b;
            assign sum_in   = '0;
            assign c_in     = in_c;
        end else begin : g_src
            assign valid_in = g_stage[gi-1].valid_reg;
            assign a_in     = g_stage[gi-1].g_opnd.a_reg;
            assign b_in     = g_stage[gi-1].g_opnd.b_reg;
            assign sum_in   = g_stage[gi-1].sum_reg;
            assign c_in     = g_stage[gi-1].c_reg;
        end

        // A stage can take new data when it is empty or its content moves on.
        if (gi == STAGES - 1) begin : g_rdy
            assign ready = !valid_reg | bus.outReady;
        end else begin : g_rdy
            assign ready = !valid_reg | g_stage[gi+1].ready;
        end

        assign load = ready & valid_in;

        // Resolve this stage's groups; the carry chains group to group.
        always_comb begin
            logic [4:0] res;
            res      = '0;
            sum_next = sum_in;
            c_next   = c_in;
            for (int gr = 0; gr < GROUPS; gr++) begin
                if (gr >= LO && gr < HI) begin
                    res = cla4(a_in[gr*4 +: 4], b_in[gr*4 +: 4], c_next);
                    sum_next[gr*4 +: 4] = res[3:0];
                    c_next = res[4];
                end
            end
        end

        // valid follows ready alone; data only moves with a real transfer,
        // so an empty output keeps its last values.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                valid_reg <= 1'b0;
                sum_reg   <= '0;
                c_reg     <= 1'b0;
            end else begin
                if (ready) begin
                    valid_reg <= valid_in;
                end
                if (load) begin
                    sum_reg <= sum_next;
                    c_reg   <= c_next;
                end
            end
        end

        // Only intermediate stages carry the unresolved operand bits forward;
        // resolved bits are cleared so they stay constant.
        if (gi < STAGES - 1) begin : g_opnd
            localparam logic [WIDTH-1:0] KEEP = upper_mask(HI);
            logic [WIDTH-1:0] a_reg;
            logic [WIDTH-1:0] b_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    a_reg <= '0;
                    b_reg <= '0;
                end else if (load) begin
                    a_reg <= a_in & KEEP;
                    b_reg <= b_in & KEEP;
                end
            end
        end
    end

    assign bus.inReady  = g_stage[0].ready;
    assign bus.outValid = g_stage[STAGES-1].valid_reg;
    assign bus.s        = g_stage[STAGES-1].sum_reg;
    assign bus.outC     = g_stage[STAGES-1].c_reg;

`ifdef ADDER_CLA_FLAGS_EN
    // Carry into the MSB is recovered from sum ^ a ^ b at that bit;
    // overflow is that carry XOR the final carry out.
    logic v_reg;
    logic z_reg;
    logic n_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_reg <= 1'b0;
            z_reg <= 1'b0;
            n_reg <= 1'b0;
        end else if (g_stage[STAGES-1].load) begin
            v_reg <= (g_stage[STAGES-1].sum_next[WIDTH-1]
                      ^ g_stage[STAGES-1].a_in[WIDTH-1]
                      ^ g_stage[STAGES-1].b_in[WIDTH-1])
                     ^ g_stage[STAGES-1].c_next;
            z_reg <= (g_stage[STAGES-1].sum_next == '0);
            n_reg <= g_stage[STAGES-1].sum_next[WIDTH-1];
        end
    end

    assign bus.outV = v_reg;
    assign bus.outZ = z_reg;
    assign bus.outN = n_reg;
`else
    assign bus.outV = 1'b0;
    assign bus.outZ = 1'b0;
    assign bus.outN = 1'b0;
`endif
endmodule

// File: tb/tb_adder_cla_pipe.sv
// ---------------------------------------------------------------------------
// tb_adder_cla_pipe
// Scoreboard bench for adder_cla_pipe (WIDTH=32, STAGES=2). The driver
// pushes the hand-computed expected result when an operand set is accepted;
// a negedge monitor pops and compares whenever a result is taken. Latency
// is counted from the cycle in which the operand set is presented and
// accepted. Flag expectations collapse to 0 when ADDER_CLA_FLAGS_EN is not
// defined.
// ---------------------------------------------------------------------------
module tb_adder_cla_pipe;
    localparam int WIDTH  = 32;
    localparam int STAGES = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    adder_cla_pipe_if #(.WIDTH(WIDTH)) bus ();

    adder_cla_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic [2:0]  f;
        int          edge_no;
        bit          lat;
        bit          consec;
    } exp_t;

    exp_t sb[$];
    int   errors   = 0;
    int   checks   = 0;
    int   edge_cnt = 0;
    int   last_pop = 0;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] fl(input logic v, input logic z, input logic n);
`ifdef ADDER_CLA_FLAGS_EN
        return {v, z, n};
`else
        return {1'b0, 1'b0, 1'b0} & {v, z, n};
`endif
    endfunction

    // Present one operand set; push its expectation at acceptance.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic ci,
                         input logic sb_mode, input logic [31:0] es, input logic ec,
                         input logic ev, input logic ez, input logic en,
                         input bit lat, input bit consec);
        int  n;
        bit  done;
        exp_t e;
        bus.a       = a;
        bus.b       = b;
        bus.inC     = ci;
        bus.sub     = sb_mode;
        bus.inValid = 1'b1;
        n    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (bus.inReady) begin
                e.s = es; e.c = ec; e.f = fl(ev, ez, en);
                e.edge_no = edge_cnt; e.lat = lat; e.consec = consec;
                sb.push_back(e);
                $display("issue a=%08h b=%08h inC=%0b sub=%0b exp s=%08h c=%0b", a, b, ci, sb_mode, es, ec);
                done = 1'b1;
            end else begin
                n++;
                if (n > 100) begin
                    check("accept_timeout", 64'd1, 64'd0);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        bus.inValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: compares each taken result, and checks that a stalled
    // result stays stable.
    logic        held_v = 1'b0;
    logic [31:0] held_s = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            held_v = 1'b0;
        end else begin
            if (bus.outValid && !bus.outReady) begin
                if (held_v) check("stall_hold", 64'(bus.s), 64'(held_s));
                held_v = 1'b1;
                held_s = bus.s;
            end else begin
                held_v = 1'b0;
            end
            if (bus.outValid && bus.outReady) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 64'(bus.s), 64'hDEAD_0000_0000);
                end else begin
                    e = sb.pop_front();
                    $display("result s=%08h c=%0b vzn=%0b%0b%0b exp s=%08h c=%0b", bus.s, bus.outC,
                             bus.outV, bus.outZ, bus.outN, e.s, e.c);
                    check("sum", 64'(bus.s), 64'(e.s));
                    check("carry", 64'(bus.outC), 64'(e.c));
                    check("flags_vzn", 64'({bus.outV, bus.outZ, bus.outN}), 64'(e.f));
                    if (e.lat) check("latency", 64'(edge_cnt - e.edge_no), 64'(STAGES));
                    if (e.consec) check("consecutive", 64'(edge_cnt), 64'(last_pop + 1));
                    last_pop = edge_cnt;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.inValid  = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.inC      = 1'b0;
        bus.sub      = 1'b0;
        bus.outReady = 1'b1;

        // Reset state
        #2;
        check("rst_outvalid", 64'(bus.outValid), 64'd0);
        check("rst_s", 64'(bus.s), 64'd0);
        check("rst_outc", 64'(bus.outC), 64'd0);
        check("rst_flags", 64'({bus.outV, bus.outZ, bus.outN}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_inready", 64'(bus.inReady), 64'd1);
        @(posedge clk);
        #1;

        // Directed arithmetic vectors, no stall
        issue(32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1, 0, 1, 1, 0);
        issue(32'hFFFFFFFF, 32'h00000000, 1, 0, 32'h00000000, 1, 0, 1, 0, 1, 0);
        issue(32'h00000005, 32'h00000007, 1, 1, 32'hFFFFFFFE, 0, 0, 0, 1, 1, 0);
        issue(32'h80000000, 32'h80000000, 0, 0, 32'h00000000, 1, 1, 1, 0, 1, 0);
        issue(32'h80000000, 32'h00000001, 0, 1, 32'h7FFFFFFF, 1, 1, 0, 0, 1, 0);
        issue(32'h00001234, 32'h00001234, 0, 1, 32'h00000000, 1, 0, 1, 0, 1, 0);
        issue(32'h0000FFFF, 32'h00000000, 1, 0, 32'h00010000, 0, 0, 0, 0, 1, 0);
        issue(32'h00000007, 32'h00000005, 0, 1, 32'h00000002, 1, 0, 0, 0, 1, 0);
        drain();

        // Backpressure: two accepts fill the pipe, third waits
        @(posedge clk);
        #1;
        bus.outReady = 1'b0;
        issue(32'd1, 32'd1, 0, 0, 32'd2, 0, 0, 0, 0, 0, 0);
        issue(32'd2, 32'd2, 0, 0, 32'd4, 0, 0, 0, 0, 0, 1);
        bus.a = 32'd3; bus.b = 32'd3; bus.inC = 1'b0; bus.sub = 1'b0;
        bus.inValid = 1'b1;
        @(negedge clk);
        check("full_inready", 64'(bus.inReady), 64'd0);
        check("full_outvalid", 64'(bus.outValid), 64'd1);
        @(negedge clk);
        check("full_inready_hold", 64'(bus.inReady), 64'd0);
        @(posedge clk);
        #1;
        bus.outReady = 1'b1;
        #1;
        check("drain_accept_ready", 64'(bus.inReady), 64'd1);
        issue(32'd3, 32'd3, 0, 0, 32'd6, 0, 0, 0, 0, 0, 1);
        drain();

        // Streaming: eight back-to-back ops
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            issue(32'(i), 32'h10, 0, 0, 32'(i) + 32'h10, 0, 0, 0, 0, 1, i > 0);
        end
        drain();

        // Reset with two ops in flight
        @(posedge clk);
        #1;
        bus.outReady = 1'b0;
        issue(32'h0000000A, 32'd1, 0, 0, 32'h0000000B, 0, 0, 0, 0, 0, 0);
        issue(32'h0000000B, 32'd1, 0, 0, 32'h0000000C, 0, 0, 0, 0, 0, 0);
        #3;
        rst = 1'b0;
        #1;
        check("midrst_outvalid", 64'(bus.outValid), 64'd0);
        check("midrst_s", 64'(bus.s), 64'd0);
        check("midrst_outc", 64'(bus.outC), 64'd0);
        sb.delete();
        bus.outReady = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_stale", 64'(bus.outValid), 64'd0);
        end
        @(posedge clk);
        #1;
        issue(32'h00000007, 32'h00000005, 1, 1, 32'h00000002, 1, 0, 0, 0, 1, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
